// File: rtl/mips_bus_arbiter_if.sv
// Avalon-style memory bus bundle shared by the CPU masters and the RAM slave.
// The master modport is the side that issues transactions; the slave modport
// is the side that answers them.
interface mips_bus_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Two-master / one-slave arbiter for the CPU memory bus.
// m0 = instruction fetch, m1 = load/store. Arbitration in IDLE is zero-cycle
// (winner forwarded combinationally); the grant is then locked until the
// slave drops waitrequest, so each grant covers exactly one transaction.
// A stall watchdog raises a sticky timeout flag after WAIT_TIMEOUT
// consecutive stalled cycles on one transaction.
// Optional: define MIPS_BUS_ARB_ROUND_ROBIN_EN to break IDLE ties in favour
// of the master not served last (default: m1 always wins ties).
module mips_bus_arbiter #(
  parameter int unsigned WAIT_TIMEOUT = 16  // legal range 2..255
) (
  input  logic                     clk,
  input  logic                     reset,
  mips_bus_arbiter_if.slave        m0,
  mips_bus_arbiter_if.slave        m1,
  mips_bus_arbiter_if.master       s,
  output logic [1:0]               grant_o,
  output logic                     timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_M0 = 2'b01, OWN_M1 = 2'b10} owner_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_TIMEOUT);

  state_e      state_q, state_d;
  owner_e      owner;
  logic [7:0]  stall_q, stall_d;
  logic        timeout_q, timeout_d;
  logic        req0, req1;
  logic        tie_to_m0;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
  // Remembers who completed last; a tie goes to the other master.
  logic last_m1_q, last_m1_d;
  assign tie_to_m0 = last_m1_q;
`else
  assign tie_to_m0 = 1'b0;
`endif

  // Current owner: locked in BUSY states, chosen by priority in IDLE.
  // Reset forces no owner so the slave sees no strobes during reset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    owner = OWN_NONE;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (req1 && !(req0 && tie_to_m0)) owner = OWN_M1;
          else if (req0)                    owner = OWN_M0;
        end
        BUSY_M0: owner = OWN_M0;
        BUSY_M1: owner = OWN_M1;
        default: owner = OWN_NONE;
      endcase
    end
  end

  // Route the owner's request to the slave; everyone else is stalled.
  always_comb begin
    s.address     = '0;
    s.read        = 1'b0;
    s.write       = 1'b0;
    s.writedata   = '0;
    s.byteenable  = '0;
    m0.waitrequest = 1'b1;
    m1.waitrequest = 1'b1;
    unique case (owner)
      OWN_M0: begin
        s.address      = m0.address;
        s.read         = m0.read;
        s.write        = m0.write;
        s.writedata    = m0.writedata;
        s.byteenable   = m0.byteenable;
        m0.waitrequest = s.waitrequest;
      end
      OWN_M1: begin
        s.address      = m1.address;
        s.read         = m1.read;
        s.write        = m1.write;
        s.writedata    = m1.writedata;
        s.byteenable   = m1.byteenable;
        m1.waitrequest = s.waitrequest;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the owner treats it as meaningful.
  assign m0.readdata = s.readdata;
  assign m1.readdata = s.readdata;

  // Next state: lock on a stall, release on completion, count stall cycles.
  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    timeout_d = timeout_q;
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
    last_m1_d = last_m1_q;
`endif
    if (owner != OWN_NONE) begin
      if (s.waitrequest) begin
        state_d = (owner == OWN_M1) ? BUSY_M1 : BUSY_M0;
        if (stall_q != 8'hFF) stall_d = stall_q + 8'd1;
        if (stall_d >= TIMEOUT_CNT) timeout_d = 1'b1;
      end else begin
        state_d = IDLE;
        stall_d = 8'd0;
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
        last_m1_d = (owner == OWN_M1);
`endif
      end
    end
  end

  // State, watchdog and last-owner registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      stall_q   <= 8'd0;
      timeout_q <= 1'b0;
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
      last_m1_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
      last_m1_q <= last_m1_d;
`endif
    end
  end

  assign grant_o   = owner;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios followed by
// randomized masters/slave, all compared against a transaction-level model.
module tb_mips_bus_arbiter;
  localparam int WT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;

  mips_bus_arbiter_if m0_bus ();
  mips_bus_arbiter_if m1_bus ();
  mips_bus_arbiter_if s_bus ();

  mips_bus_arbiter #(.WAIT_TIMEOUT(WT)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          active;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } txn_t;

  // Reference model: who holds the bus (-1 = nobody), stall run length,
  // sticky timeout, and who finished last (1 = m1, as after reset).
  int lock_owner = -1;
  int stall_run  = 0;
  int last_done  = 1;
  bit to_exp     = 1'b0;
  bit done0, done1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic drive(input int m, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (m == 0) begin
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
      m0_bus.writedata = wd; m0_bus.byteenable = be;
    end else begin
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
      m1_bus.writedata = wd; m1_bus.byteenable = be;
    end
  endtask

  task automatic idle(input int m);
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Who the rules say should own the bus this cycle.
  function automatic int expected_owner();
    bit r0, r1;
    r0 = m0_bus.read | m0_bus.write;
    r1 = m1_bus.read | m1_bus.write;
    if (reset) return -1;
    if (lock_owner >= 0) return lock_owner;
    if (r0 && r1) begin
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
      return (last_done == 1) ? 0 : 1;
`else
      return 1;
`endif
    end
    if (r1) return 1;
    if (r0) return 0;
    return -1;
  endfunction

  // Compare all DUT outputs against the model, then advance the model.
  task automatic sample();
    int          own;
    logic [1:0]  eg;
    logic [69:0] es;
    logic [1:0]  ew;
    @(negedge clk);
    own = expected_owner();
    eg  = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
    if (own == 0)
      es = {m0_bus.address, m0_bus.read, m0_bus.write, m0_bus.writedata, m0_bus.byteenable};
    else if (own == 1)
      es = {m1_bus.address, m1_bus.read, m1_bus.write, m1_bus.writedata, m1_bus.byteenable};
    else
      es = '0;
    ew = {(own == 1) ? s_bus.waitrequest : 1'b1, (own == 0) ? s_bus.waitrequest : 1'b1};
    check("grant", grant, eg);
    check("s_bus", {s_bus.address, s_bus.read, s_bus.write, s_bus.writedata, s_bus.byteenable}, es);
    check("m_wait", {m1_bus.waitrequest, m0_bus.waitrequest}, ew);
    check("m_rdata", {m1_bus.readdata, m0_bus.readdata}, {2{s_bus.readdata}});
    check("timeout", timeout, to_exp);
    done0 = (own == 0) && !s_bus.waitrequest;
    done1 = (own == 1) && !s_bus.waitrequest;
    if (reset) begin
      lock_owner = -1; stall_run = 0; to_exp = 1'b0; last_done = 1;
    end else if (own >= 0) begin
      if (s_bus.waitrequest) begin
        lock_owner = own;
        if (stall_run < 255) stall_run++;
        if (stall_run >= WT) to_exp = 1'b1;
      end else begin
        lock_owner = -1; stall_run = 0; last_done = own;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    txn_t t[2];
    logic [1:0] seq_grant[6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    bit         seq_wait[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    idle(0); idle(1);
    s_bus.waitrequest = 1'b0;
    s_bus.readdata    = 32'h0;
    advance();

    // Reset with both masters requesting: bus must stay quiet.
    drive(0, 1, 0, 32'h1000, 32'h0, 4'hF);
    drive(1, 0, 1, 32'h2000, 32'h5555, 4'h3);
    sample(); advance();
    reset = 1'b0;
    idle(0); idle(1);
    sample(); advance();

    // Single zero-wait fetch completes in the arbitration cycle.
    drive(0, 1, 0, 32'hBFC00000, 32'h0, 4'hF);
    s_bus.readdata = 32'h1CA759FE;
    sample();
    check("fetch_grant", grant, 2'b01);
    check("fetch_wait", m0_bus.waitrequest, 1'b0);
    check("fetch_rdata", m0_bus.readdata, 32'h1CA759FE);
    advance();
    idle(0);

    // Simultaneous fetch and store, two stall cycles each: store first.
    drive(0, 1, 0, 32'hBFC00004, 32'h0, 4'hF);
    drive(1, 0, 1, 32'h00000040, 32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 6; i++) begin
      s_bus.waitrequest = seq_wait[i];
      sample();
      check("prio_seq", grant, seq_grant[i]);
      advance();
      if (i == 2) idle(1);
      if (i == 5) idle(0);
    end

    // m1 arrives while m0 is stalled: no preemption.
    drive(0, 1, 0, 32'h00000100, 32'h0, 4'hF);
    s_bus.waitrequest = 1'b1;
    sample(); check("lock_c0", grant, 2'b01); advance();
    drive(1, 1, 0, 32'h00000200, 32'h0, 4'hF);
    sample(); check("lock_c1", grant, 2'b01); advance();
    s_bus.waitrequest = 1'b0;
    sample(); check("lock_c2", grant, 2'b01); advance();
    idle(0);
    sample(); check("lock_c3", grant, 2'b10); advance();
    idle(1);

    // Watchdog: hung slave trips timeout after WT stalled cycles, sticky.
    drive(0, 1, 0, 32'h00000300, 32'h0, 4'hF);
    s_bus.waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      check("to_stall", timeout, (i >= WT) ? 1'b1 : 1'b0);
      advance();
    end
    s_bus.waitrequest = 1'b0;
    sample(); check("to_done", timeout, 1'b1); advance();
    idle(0);
    sample(); check("to_sticky", timeout, 1'b1); advance();
    reset = 1'b1;
    sample(); advance();
    reset = 1'b0;
    sample(); check("to_cleared", timeout, 1'b0); advance();

    // Reset during BUSY_M1 drops the transaction.
    drive(1, 1, 0, 32'h00000400, 32'h0, 4'hF);
    s_bus.waitrequest = 1'b1;
    sample(); advance();
    reset = 1'b1;
    sample();
    check("rst_grant", grant, 2'b00);
    check("rst_strobes", {s_bus.read, s_bus.write}, 2'b00);
    check("rst_wait", {m1_bus.waitrequest, m0_bus.waitrequest}, 2'b11);
    advance();
    reset = 1'b0;
    idle(1);
    s_bus.waitrequest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample(); check("rst_idle", grant, 2'b00); advance();
    end

    // Both masters requesting continuously with a zero-wait slave.
    drive(0, 1, 0, 32'h00000500, 32'h0, 4'hF);
    drive(1, 1, 0, 32'h00000600, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      sample();
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
      check("tie_seq", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      check("tie_seq", grant, 2'b10);
`endif
      advance();
    end
    idle(0); idle(1);

    // Randomized traffic; masters hold requests until they see completion.
    t[0].active = 1'b0;
    t[1].active = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!t[m].active && $urandom_range(0, 2) != 0) begin
          t[m].active = 1'b1;
          t[m].rd     = 1'($urandom_range(0, 1));
          t[m].wr     = !t[m].rd;
          t[m].addr   = $urandom;
          t[m].wd     = $urandom;
          t[m].be     = 4'($urandom);
        end
        if (t[m].active) drive(m, t[m].rd, t[m].wr, t[m].addr, t[m].wd, t[m].be);
        else idle(m);
      end
      s_bus.waitrequest = ($urandom_range(0, 3) == 0);
      s_bus.readdata    = $urandom;
      reset             = ($urandom_range(0, 99) == 0);
      sample();
      if (done0) t[0].active = 1'b0;
      if (done1) t[1].active = 1'b0;
      advance();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU's Avalon-style memory bus (address/read/write/waitrequest/writedata/byteenable/readdata).
- Shares a single RAM slave between the instruction-fetch master (m0) and the load/store master (m1).
- Grant is locked for the whole transaction, including waitrequest stalls. A stall watchdog flags a hung slave.

Parameters:
- WAIT_TIMEOUT, 16, number of consecutive stalled cycles on one transaction that sets the timeout flag (range 2..255).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- m0_address  input  32  instruction master address
- m0_read  input  1  instruction master read strobe
- m0_write  input  1  instruction master write strobe
- m0_writedata  input  32  instruction master write data
- m0_byteenable  input  4  instruction master byte enables
- m0_waitrequest  output  1  stall to m0
- m0_readdata  output  32  read data to m0
- m1_*  (same set as m0_*)  data master
- s_address  output  32  to slave
- s_read  output  1  to slave
- s_write  output  1  to slave
- s_writedata  output  32  to slave
- s_byteenable  output  4  to slave
- s_waitrequest  input  1  from slave
- s_readdata  input  32  from slave
- grant  output  2  current owner: 00 none, 01 m0, 10 m1
- timeout  output  1  sticky stall-watchdog flag

Behaviour:
- Interface timing: one clock, clk; reset is synchronous and active-high.
- Request definition: a master requests when read|write is high. Masters hold all signals stable while their waitrequest is high.
- Completion: a transaction completes in the cycle where the owner's strobe is high and s_waitrequest=0. s_readdata is valid in that cycle.
- States: IDLE, BUSY_M0, BUSY_M1.
- IDLE:
  - Winner is chosen combinationally and forwarded to the slave in the same cycle (zero-cycle arbitration).
  - If s_waitrequest=0, the transaction completes and the state stays IDLE.
  - Otherwise the state moves to BUSY_<winner>.
- BUSY_x:
  - Owner x is forwarded regardless of the other master's requests; no preemption.
  - On s_waitrequest=0, return to IDLE. Re-arbitration happens in the next cycle, so there is one transaction per grant.
- Priority: fixed, m1 over m0. A pending data access must finish before the next fetch.
- Forwarding:
  - Owner: gets m_waitrequest = s_waitrequest.
  - Non-owner: gets m_waitrequest=1.
  - s_readdata is broadcast to both m_readdata outputs and is meaningful only to the owner.
  - No owner: s_address=0, s_read=0, s_write=0, s_writedata=0, s_byteenable=0, both m_waitrequest=1, grant=00.
- A master asserting read and write together is illegal. It is forwarded unchanged and is not checked.
- Watchdog:
  - 8-bit stall counter increments every cycle that has an owner and s_waitrequest=1.
  - Clears on completion.
  - When the count reaches WAIT_TIMEOUT, timeout is set (registered, visible from the next cycle) and stays high until reset.
  - The transaction is not aborted.
- Reset:
  - While reset is high: state IDLE, counter 0, timeout 0, grant 00, all slave strobes 0, both m_waitrequest=1.
  - Reset mid-transaction drops the transaction; the master must reissue it.
  - Reset values of the remaining outputs: s_address, s_writedata and s_byteenable are 0; m_readdata follows s_readdata.

Optional Feature:
- MIPS_BUS_ARB_ROUND_ROBIN_EN defined:
  - Ties in IDLE go to the master not served last.
  - A 1-bit last-owner register updates on each completion and resets to m1, so the first tie goes to m0.
  - Non-tie behaviour is unchanged.
- Not defined: fixed m1-over-m0 priority; no last-owner register.

Test Plan:
- m0 read 0xBFC00000 alone, s_waitrequest=0, s_readdata=0x1CA759FE -> same cycle grant=01, s_read=1, m0_waitrequest=0, m0_readdata=0x1CA759FE; state stays IDLE.
- m0 read and m1 write (0x00000040, data 0xDEADBEEF, be 1111) together, slave stalls 2 cycles per access -> m1 served first (grant=10 for 3 cycles) with m0_waitrequest=1 throughout; m0 granted on the following cycle and completes 3 cycles later.
- m0 read stalled (BUSY_M0), m1 raises a request on stall cycle 1 -> grant stays 01 until m0 completes; m1 served next cycle.
- WAIT_TIMEOUT=4, s_waitrequest held high with m0 reading -> timeout=0 for the first 4 stalled cycles, 1 from cycle 5 onward; stays 1 after the slave releases and the transaction completes; cleared only by reset.
- Reset pulsed during BUSY_M1 -> in the reset cycle s_read=s_write=0, grant=00, both m_waitrequest=1; after reset with no requests, state stays IDLE.
- With MIPS_BUS_ARB_ROUND_ROBIN_EN, both masters requesting continuously, zero-wait slave -> grant sequence 01,10,01,10; without the macro -> 10 every cycle.
